// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - instruction fetch and time-step sequencer (optional ack timeout: SEQ_TIMEOUT_EN)
module proc_sequencer #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 8,
    parameter int TMO_CYC = 15
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Run,
    output logic              IMem_req,
    output logic [ADDR_W-1:0] IMem_addr,
    input  logic              IMem_ack,
    input  logic [DATA_W-1:0] IMem_data,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] Din,
    output logic [1:0]        Step,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_IMM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [1:0]        step_q, step_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              xfer;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);
    logic [3:0] wait_q, wait_d;
`endif

    assign xfer   = req_q & IMem_ack;
    assign opcode = IMem_data[DATA_W-1 -: 4];
    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        din_d   = din_q;
        step_d  = 2'b00;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (xfer) begin
                    ir_d = IMem_data;
                    pc_d = pc_inc;
                    case (opcode)
                        OP_MVI:  state_d = S_IMM;
                        OP_HALT: state_d = S_HALT;
                        default: begin
                            state_d = S_EXEC;
                            step_d  = 2'b01;
                        end
                    endcase
                end
            end
            S_IMM: begin
                if (xfer) begin
                    din_d   = IMem_data;
                    pc_d    = pc_inc;
                    state_d = S_EXEC;
                    step_d  = 2'b01;
                end
            end
            S_EXEC: begin
                if (Done) begin
                    state_d = S_FETCH;
                end else if (step_q != 2'b11) begin
                    step_d = step_q + 2'b01;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        wait_d = 4'd0;
        if (req_q && !IMem_ack) begin
            if (wait_q == TMO_LAST) begin
                fault_d = 1'b1;
                state_d = S_HALT;
                step_d  = 2'b00;
            end else begin
                wait_d = wait_q + 4'd1;
            end
        end
`endif

        // First IMM cycle keeps req low to separate it from the opcode fetch.
        req_d    = (state_d == S_FETCH) || ((state_d == S_IMM) && (state_q == S_IMM));
        busy_d   = (state_d == S_FETCH) || (state_d == S_IMM) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            din_q    <= '0;
            step_q   <= 2'b00;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            din_q    <= din_d;
            step_q   <= step_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) wait_q <= 4'd0;
        else       wait_q <= wait_d;
    end
`endif

    assign IMem_req  = req_q;
    assign IMem_addr = pc_q;
    assign IR        = ir_q;
    assign Din       = din_q;
    assign Step      = step_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign Fault     = fault_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - bench for proc_sequencer with memory/decoder models and fetch-address scoreboard
module tb_proc_sequencer;

    logic       Clock = 1'b0;
    logic       Clear;
    logic       Run;
    logic       IMem_req;
    logic [7:0] IMem_addr;
    logic       IMem_ack  = 1'b0;
    logic [9:0] IMem_data = 10'h000;
    logic [9:0] IR;
    logic [9:0] Din;
    logic [1:0] Step;
    logic       Done      = 1'b0;
    logic       Busy;
    logic       Halted;
    logic       Fault;

    logic [9:0] mem [256];
    logic [7:0] exp_addr_q [$];
    int         ack_delay;
    int         done_at;
    int         wait_cnt;
    bit         withhold;
    bit         force_ack;
    int         n_checks;
    int         n_errors;

    proc_sequencer #(.DATA_W(10), .ADDR_W(8), .TMO_CYC(15)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Run       (Run),
        .IMem_req  (IMem_req),
        .IMem_addr (IMem_addr),
        .IMem_ack  (IMem_ack),
        .IMem_data (IMem_data),
        .IR        (IR),
        .Din       (Din),
        .Step      (Step),
        .Done      (Done),
        .Busy      (Busy),
        .Halted    (Halted),
        .Fault     (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory and decoder models: drive inputs on the falling edge.
    always @(negedge Clock) begin
        Done = (done_at != 0) && (int'(Step) == done_at);
        if (force_ack) begin
            IMem_ack  = 1'b1;
            IMem_data = mem[IMem_addr];
        end else if (IMem_req && !Clear && !withhold) begin
            if (wait_cnt >= ack_delay) begin
                IMem_ack  = 1'b1;
                IMem_data = mem[IMem_addr];
                wait_cnt  = 0;
                if (exp_addr_q.size() > 0) check("fetch_addr", 32'(IMem_addr), 32'(exp_addr_q.pop_front()));
                else                       check("fetch_expected", exp_addr_q.size(), 1);
            end else begin
                IMem_ack  = 1'b0;
                IMem_data = 10'($urandom);
                wait_cnt++;
            end
        end else begin
            IMem_ack  = 1'b0;
            IMem_data = 10'($urandom);
            wait_cnt  = 0;
        end
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic do_clear();
        Clear     = 1'b1;
        Run       = 1'b0;
        withhold  = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        exp_addr_q.delete();
        tick();
        tick();
        Clear = 1'b0;
        tick();
    endtask

    initial begin
        int cnt;
        bit saw_ff;
        bit wrapped;
        n_checks  = 0;
        n_errors  = 0;
        Clear     = 1'b1;
        Run       = 1'b0;
        ack_delay = 0;
        done_at   = 0;
        withhold  = 1'b0;
        force_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 10'h00A;
        tick();
        tick();
        Clear = 1'b0;
        tick();

        check("rst_req", IMem_req, 0);
        check("rst_addr", IMem_addr, 0);
        check("rst_ir", IR, 0);
        check("rst_din", Din, 0);
        check("rst_step", Step, 0);
        check("rst_busy", Busy, 0);
        check("rst_halted", Halted, 0);
        check("rst_fault", Fault, 0);

        // mv, zero-wait, Done at step 01, then halt
        mem[1]  = 10'h3C0;
        done_at = 1;
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        Run = 1'b1;
        tick();
        check("mv_c1_req", IMem_req, 1);
        check("mv_c1_busy", Busy, 1);
        check("mv_c1_step", Step, 0);
        tick();
        Run = 1'b0;
        check("mv_ir", IR, 10'h00A);
        check("mv_step1", Step, 1);
        check("mv_c2_req", IMem_req, 0);
        check("mv_pc", IMem_addr, 1);
        tick();
        check("mv_step0", Step, 0);
        check("mv_latency_req", IMem_req, 1);
        check("mv_next_addr", IMem_addr, 1);
        tick();
        check("halt_halted", Halted, 1);
        check("halt_busy", Busy, 0);
        check("halt_ir", IR, 10'h3C0);
        check("mv_drain", exp_addr_q.size(), 0);

        // mvi with 2-cycle ack delay
        do_clear();
        mem[0]    = 10'h058;
        mem[1]    = 10'h155;
        mem[2]    = 10'h3C0;
        ack_delay = 2;
        done_at   = 1;
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        exp_addr_q.push_back(8'd2);
        Run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            Run = 1'b0;
            check("mvi_fetch_req", IMem_req, 1);
        end
        tick();
        check("mvi_gap_req", IMem_req, 0);
        check("mvi_ir", IR, 10'h058);
        check("mvi_gap_addr", IMem_addr, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mvi_imm_req", IMem_req, 1);
            check("mvi_imm_step", Step, 0);
        end
        tick();
        check("mvi_din", Din, 10'h155);
        check("mvi_step1", Step, 1);
        check("mvi_pc", IMem_addr, 2);
        cnt = 0;
        while (!Halted && cnt < 20) begin tick(); cnt++; end
        check("mvi_halted", Halted, 1);
        check("mvi_din_hold", Din, 10'h155);
        check("mvi_drain", exp_addr_q.size(), 0);

        // ALU op, Done at step 11
        do_clear();
        mem[0]  = 10'h081;
        mem[1]  = 10'h3C0;
        done_at = 3;
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        Run = 1'b1;
        tick();
        Run = 1'b0;
        check("alu_fetch_req", IMem_req, 1);
        for (int s = 1; s <= 3; s++) begin
            tick();
            check("alu_step", Step, s);
        end
        tick();
        check("alu_step0", Step, 0);
        check("alu_latency_req", IMem_req, 1);
        check("alu_next_addr", IMem_addr, 1);
        tick();
        check("alu_halted", Halted, 1);
        check("alu_drain", exp_addr_q.size(), 0);

        // ALU op without Done: step overflow fault
        do_clear();
        done_at = 0;
        exp_addr_q.push_back(8'd0);
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        tick();
        check("ovf_step3", Step, 3);
        check("ovf_fault_early", Fault, 0);
        tick();
        check("ovf_fault", Fault, 1);
        check("ovf_halted", Halted, 1);
        check("ovf_step", Step, 0);
        check("ovf_busy", Busy, 0);
        check("ovf_drain", exp_addr_q.size(), 0);

        // PC wrap after 256 mv's, then halt at address 0
        do_clear();
        check("clear_fault", Fault, 0);
        for (int i = 0; i < 256; i++) mem[i] = 10'h00A;
        for (int i = 0; i < 256; i++) exp_addr_q.push_back(8'(i));
        exp_addr_q.push_back(8'd0);
        done_at = 1;
        Run     = 1'b1;
        saw_ff  = 1'b0;
        wrapped = 1'b0;
        cnt     = 0;
        while (!Halted && cnt < 1000) begin
            tick();
            cnt++;
            if (cnt == 10) mem[0] = 10'h3C0;
            if (IMem_req && IMem_addr == 8'hFF) saw_ff = 1'b1;
            else if (IMem_req && saw_ff && !wrapped) begin
                check("wrap_addr", IMem_addr, 0);
                wrapped = 1'b1;
            end
        end
        check("wrap_seen", wrapped, 1);
        check("wrap_halted", Halted, 1);
        check("wrap_ir", IR, 10'h3C0);
        check("wrap_pc", IMem_addr, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_run_halted", Halted, 1);
            check("halt_run_busy", Busy, 0);
            check("halt_run_req", IMem_req, 0);
        end
        Run = 1'b0;
        check("wrap_drain", exp_addr_q.size(), 0);

        // Clear during a pending fetch, late ack ignored
        do_clear();
        for (int i = 0; i < 4; i++) mem[i] = 10'h00A;
        done_at = 1;
        exp_addr_q.push_back(8'd0);
        Run = 1'b1;
        tick();
        tick();
        Run      = 1'b0;
        withhold = 1'b1;
        tick();
        check("clr_pre_req", IMem_req, 1);
        check("clr_pre_addr", IMem_addr, 1);
        check("clr_pre_ir", IR, 10'h00A);
        Clear = 1'b1;
        #1;
        check("clr_req", IMem_req, 0);
        check("clr_addr", IMem_addr, 0);
        check("clr_ir", IR, 0);
        check("clr_step", Step, 0);
        check("clr_busy", Busy, 0);
        check("clr_halted", Halted, 0);
        check("clr_fault", Fault, 0);
        force_ack = 1'b1;
        tick();
        tick();
        Clear = 1'b0;
        tick();
        check("late_ack_req", IMem_req, 0);
        check("late_ack_ir", IR, 0);
        check("late_ack_addr", IMem_addr, 0);
        check("late_ack_busy", Busy, 0);
        force_ack = 1'b0;
        check("clr_drain", exp_addr_q.size(), 0);

        // Ack withheld: timeout fault or indefinite wait
        do_clear();
        withhold = 1'b1;
        Run      = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (IMem_req) cnt++;
            else if (cnt > 0) break;
        end
`ifdef SEQ_TIMEOUT_EN
        check("tmo_req_cycles", cnt, 15);
        check("tmo_fault", Fault, 1);
        check("tmo_halted", Halted, 1);
        check("tmo_req", IMem_req, 0);
`else
        check("no_tmo_req_cycles", cnt, 100);
        check("no_tmo_fault", Fault, 0);
        check("no_tmo_req", IMem_req, 1);
`endif
        Run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
